// File: rtl/aer_out_encoder.sv
// AER transmit encoder: spike vectors and time-step markers are queued in a FIFO,
// then serialised one address at a time over a 4-phase REQ/ACK bus.
module aer_out_encoder #(
    parameter int POST_NEUR_PARALLEL   = 4,
    parameter int POST_NEUR_ADDR_WIDTH = 10,
    parameter int AER_WIDTH            = 12,
    parameter int FIFO_DEPTH           = 8
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [POST_NEUR_PARALLEL-1:0]   NEUR_EVENT_OUT,
    input  logic                            NEUR_EVENT_VALID,
    input  logic [POST_NEUR_ADDR_WIDTH-1:0] NEUR_GROUP_ADDR,
    input  logic                            TSTEP_MARK,
    output logic [AER_WIDTH-1:0]            AEROUT_ADDR,
    output logic                            AEROUT_REQ,
    input  logic                            AEROUT_ACK,
    output logic                            FIFO_FULL,
    output logic                            BUSY,
    output logic                            OVERFLOW
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int IDX_W   = (POST_NEUR_PARALLEL > 1) ? $clog2(POST_NEUR_PARALLEL) : 1;
    localparam int ENTRY_W = 1 + POST_NEUR_ADDR_WIDTH + POST_NEUR_PARALLEL;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_WAIT_HI = 2'd2;
    localparam logic [1:0] ST_WAIT_LO = 2'd3;

    // Input capture stage; zero vectors are filtered here so they never occupy a slot.
    logic                            r_in_valid;
    logic [POST_NEUR_ADDR_WIDTH-1:0] r_in_group;
    logic [POST_NEUR_PARALLEL-1:0]   r_in_vec;
    logic                            r_mark_pend;
    logic                            r_overflow;

    logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W:0]     r_wr_ptr;
    logic [PTR_W:0]     r_rd_ptr;

    logic                            r_ack_meta;
    logic                            r_ack_s;
    logic [1:0]                      r_state;
    logic                            r_mark;
    logic [POST_NEUR_ADDR_WIDTH-1:0] r_group;
    logic [POST_NEUR_PARALLEL-1:0]   r_vec;
    logic [IDX_W-1:0]                r_bit;
    logic [AER_WIDTH-1:0]            r_addr;
    logic                            r_req;

    logic                            w_full;
    logic                            w_empty;
    logic                            w_spike_push;
    logic                            w_mark_push;
    logic                            w_wr_en;
    logic [ENTRY_W-1:0]              w_wr_data;
    logic [ENTRY_W-1:0]              w_rd_data;
    logic                            w_rd_mark;
    logic [POST_NEUR_ADDR_WIDTH-1:0] w_rd_group;
    logic [POST_NEUR_PARALLEL-1:0]   w_rd_vec;
    logic                            w_pop;
    logic [IDX_W-1:0]                w_low_idx;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

    // Spikes have priority over a pending marker, which keeps same-cycle spikes ahead of it.
    assign w_spike_push = r_in_valid;
    assign w_mark_push  = r_mark_pend & ~w_spike_push & ~w_full;
    assign w_wr_en      = (w_spike_push & ~w_full) | w_mark_push;
    assign w_wr_data    = w_spike_push ? {1'b0, r_in_group, r_in_vec}
                                       : {1'b1, {(ENTRY_W-1){1'b0}}};

    assign w_rd_data  = r_mem[r_rd_ptr[PTR_W-1:0]];
    assign w_rd_mark  = w_rd_data[ENTRY_W-1];
    assign w_rd_group = w_rd_data[POST_NEUR_PARALLEL +: POST_NEUR_ADDR_WIDTH];
    assign w_rd_vec   = w_rd_data[POST_NEUR_PARALLEL-1:0];

    assign w_pop = ~w_empty &&
                   ((r_state == ST_IDLE) ||
                    ((r_state == ST_WAIT_LO) && ~r_ack_s && (r_vec == '0)));

    always_comb begin
        w_low_idx = '0;
        for (int unsigned i = POST_NEUR_PARALLEL; i > 0; i--) begin
            if (r_vec[i-1]) begin
                w_low_idx = IDX_W'(i - 1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_in_valid  <= 1'b0;
            r_in_group  <= '0;
            r_in_vec    <= '0;
            r_mark_pend <= 1'b0;
            r_overflow  <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_ack_meta  <= 1'b0;
            r_ack_s     <= 1'b0;
        end else begin
            r_in_valid  <= NEUR_EVENT_VALID & (|NEUR_EVENT_OUT);
            r_in_group  <= NEUR_GROUP_ADDR;
            r_in_vec    <= NEUR_EVENT_OUT;
            r_mark_pend <= (r_mark_pend & ~w_mark_push) | TSTEP_MARK;
            if (w_spike_push && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
            end
            r_ack_meta <= AEROUT_ACK;
            r_ack_s    <= r_ack_meta;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= w_wr_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_mark  <= 1'b0;
            r_group <= '0;
            r_vec   <= '0;
            r_bit   <= '0;
            r_addr  <= '0;
            r_req   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_mark  <= w_rd_mark;
                        r_group <= w_rd_group;
                        r_vec   <= w_rd_vec;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_req <= 1'b1;
                    r_bit <= w_low_idx;
                    if (r_mark) begin
                        r_addr <= {2'b10, {POST_NEUR_ADDR_WIDTH{1'b0}}};
                    end else begin
                        r_addr <= {2'b00, r_group + POST_NEUR_ADDR_WIDTH'(w_low_idx)};
                    end
                    r_state <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    if (r_ack_s) begin
                        r_req <= 1'b0;
                        if (r_mark) begin
                            r_mark <= 1'b0;
                        end else begin
                            r_vec[r_bit] <= 1'b0;
                        end
                        r_state <= ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    if (!r_ack_s) begin
                        if (r_vec != '0) begin
                            r_state <= ST_LOAD;
                        end else if (w_pop) begin
                            r_mark  <= w_rd_mark;
                            r_group <= w_rd_group;
                            r_vec   <= w_rd_vec;
                            r_state <= ST_LOAD;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign AEROUT_ADDR = r_addr;
    assign AEROUT_REQ  = r_req;
    assign FIFO_FULL   = w_full;
    assign OVERFLOW    = r_overflow;
    assign BUSY        = ~w_empty | (r_state != ST_IDLE) | r_mark_pend;

endmodule

// File: tb/tb_aer_out_encoder.sv
// Bench for aer_out_encoder: directed scenarios plus random bursts checked against
// an ordered event list built from the spike/marker rules.
`timescale 1ns/1ps
module tb_aer_out_encoder;

    logic        clk;
    logic        rst;
    logic [3:0]  ev_out;
    logic        ev_valid;
    logic [9:0]  grp;
    logic        tstep;
    logic [11:0] aer_addr;
    logic        req;
    logic        ack;
    logic        full;
    logic        busy;
    logic        ovf;

    int n_checks = 0;
    int n_errors = 0;

    logic [11:0] exp_q[$];
    logic [11:0] obs_q[$];
    int          base = 0;
    int          resp_mode = 0;
    int unsigned resp_dly = 1;

    aer_out_encoder #(
        .POST_NEUR_PARALLEL  (4),
        .POST_NEUR_ADDR_WIDTH(10),
        .AER_WIDTH           (12),
        .FIFO_DEPTH          (8)
    ) dut (
        .CLK             (clk),
        .RST             (rst),
        .NEUR_EVENT_OUT  (ev_out),
        .NEUR_EVENT_VALID(ev_valid),
        .NEUR_GROUP_ADDR (grp),
        .TSTEP_MARK      (tstep),
        .AEROUT_ADDR     (aer_addr),
        .AEROUT_REQ      (req),
        .AEROUT_ACK      (ack),
        .FIFO_FULL       (full),
        .BUSY            (busy),
        .OVERFLOW        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Receiver: mode 0 holds ACK low, 1 follows REQ after resp_dly cycles, 2 toggles freely.
    initial begin
        int unsigned cnt;
        ack = 1'b0;
        cnt = 0;
        forever begin
            @(negedge clk);
            case (resp_mode)
                0: begin ack = 1'b0; cnt = 0; end
                1: begin
                    if (req != ack) begin
                        cnt++;
                        if (cnt >= resp_dly) begin
                            ack = req;
                            cnt = 0;
                        end
                    end else begin
                        cnt = 0;
                    end
                end
                default: begin ack = ~ack; cnt = 0; end
            endcase
        end
    end

    // Each REQ rising edge is one transmitted event.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (req && !prev) obs_q.push_back(aer_addr);
                prev = req;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [3:0] vec, input logic [9:0] g, input logic t);
        @(negedge clk);
        ev_valid = v;
        ev_out   = vec;
        grp      = g;
        tstep    = t;
    endtask

    // Reference model: spikes of a vector leave in ascending address order, then the marker.
    task automatic expect_vec(input logic [3:0] vec, input logic [9:0] g);
        for (int i = 0; i < 4; i++)
            if (vec[i]) exp_q.push_back({2'b00, 10'(g + 10'(i))});
    endtask

    task automatic expect_mark();
        exp_q.push_back(12'h800);
    endtask

    task automatic drain(input string tag);
        int cyc;
        int n_obs;
        cyc = 0;
        repeat (3) @(negedge clk);
        while (((obs_q.size() - base) != exp_q.size() || busy || req || ack) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        n_obs = obs_q.size() - base;
        check({tag, "_count"}, n_obs, exp_q.size());
        check({tag, "_busy"}, busy, 0);
        for (int k = 0; k < exp_q.size() && k < n_obs; k++)
            check({tag, "_ev"}, obs_q[base + k], exp_q[k]);
        base = obs_q.size();
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base = obs_q.size();
    endtask

    initial begin
        int lat;
        int bad;
        ev_valid = 1'b0;
        ev_out   = '0;
        grp      = '0;
        tstep    = 1'b0;
        rst      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", req, 0);
        check("rst_addr", aer_addr, 0);
        check("rst_full", full, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single vector with latency measurement.
        resp_mode = 1;
        resp_dly  = 3;
        base = obs_q.size();
        @(negedge clk);
        ev_valid = 1'b1; ev_out = 4'b1010; grp = 10'h008;
        @(posedge clk);
        #1;
        ev_valid = 1'b0; ev_out = '0;
        lat = 0;
        while (!req && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, 3);
        expect_vec(4'b1010, 10'h008);
        drain("single");

        // Back-to-back vectors including the top group.
        step(1'b1, 4'b0001, 10'h000, 1'b0);
        step(1'b1, 4'b1000, 10'h004, 1'b0);
        step(1'b1, 4'b1111, 10'h3FC, 1'b0);
        step(1'b0, 4'b0000, 10'h000, 1'b0);
        expect_vec(4'b0001, 10'h000);
        expect_vec(4'b1000, 10'h004);
        expect_vec(4'b1111, 10'h3FC);
        drain("b2b");
        check("b2b_ovf", ovf, 0);

        // Overflow with ACK held low.
        resp_mode = 0;
        for (int k = 0; k < 10; k++) step(1'b1, 4'b0001, 10'(k * 4), 1'b0);
        step(1'b0, 4'b0000, 10'h000, 1'b0);
        repeat (3) @(negedge clk);
        check("ovf_full", full, 1);
        check("ovf_flag", ovf, 1);
        check("ovf_req", req, 1);
        check("ovf_busy", busy, 1);
        for (int k = 0; k < 9; k++) expect_vec(4'b0001, 10'(k * 4));
        resp_mode = 1;
        resp_dly  = 1;
        drain("ovf");
        check("ovf_sticky", ovf, 1);
        check("ovf_full_drained", full, 0);
        do_reset();
        check("ovf_cleared", ovf, 0);

        // Same-cycle spike and marker.
        step(1'b1, 4'b0100, 10'h010, 1'b1);
        step(1'b0, 4'b0000, 10'h000, 1'b0);
        expect_vec(4'b0100, 10'h010);
        expect_mark();
        drain("mark");

        // Reset in the middle of a handshake.
        resp_mode = 0;
        for (int k = 0; k < 4; k++) step(1'b1, 4'b0001, 10'(k * 4), 1'b0);
        step(1'b0, 4'b0000, 10'h000, 1'b0);
        repeat (6) @(negedge clk);
        check("midrst_req_before", req, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_req", req, 0);
        check("midrst_busy", busy, 0);
        check("midrst_full", full, 0);
        @(negedge clk);
        rst = 1'b0;
        base = obs_q.size();
        resp_mode = 2;
        repeat (12) @(negedge clk);
        resp_mode = 0;
        repeat (2) @(negedge clk);
        check("midrst_noev", obs_q.size() - base, 0);
        check("midrst_busy_after", busy, 0);

        // Zero vector is ignored.
        resp_mode = 1;
        step(1'b1, 4'b0000, 10'h020, 1'b0);
        step(1'b0, 4'b0000, 10'h000, 1'b0);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (req || busy) bad++;
        end
        check("zero_vec_quiet", bad, 0);
        check("zero_vec_noev", obs_q.size() - base, 0);

        // Random bursts of at most FIFO_DEPTH entries; a marker is followed by an idle cycle.
        for (int b = 0; b < 30; b++) begin
            int   entries;
            logic prev_t;
            resp_dly = $urandom_range(1, 4);
            entries  = 0;
            prev_t   = 1'b0;
            for (int c = 0; c < 10; c++) begin
                int          act;
                int          need;
                logic [3:0]  v;
                logic [9:0]  g;
                logic        dv;
                logic        dt;
                act = prev_t ? 0 : int'($urandom_range(0, 3));
                v   = 4'($urandom);
                g   = 10'($urandom_range(0, 255) * 4);
                dv  = (act == 1 || act == 3);
                dt  = (act == 2 || act == 3);
                need = ((dv && v != 0) ? 1 : 0) + (dt ? 1 : 0);
                if (entries + need > 8) begin
                    dv = 1'b0;
                    dt = 1'b0;
                    need = 0;
                end
                entries += need;
                step(dv, v, g, dt);
                if (dv) expect_vec(v, g);
                if (dt) expect_mark();
                prev_t = dt;
            end
            step(1'b0, 4'b0000, 10'h000, 1'b0);
            drain("rand");
        end
        check("rand_ovf", ovf, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
